// File: rtl/mac_array_engine.sv
// Multi-channel MAC engine: per-channel operand FIFOs drained in lockstep
// through a two-stage multiply/accumulate pipeline.
//  state | meaning
//  IDLE  | FIFOs empty, waiting for the first accepted write
//  FILL  | accepting operand writes
//  EXEC  | popping all channels in lockstep, pipeline draining
//  DONE  | results held until clear
module mac_array_engine #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int NUM_CH     = 2,
  parameter int ACC_W      = 24,
  parameter int AUTO_START = 1,
  parameter int SATURATE   = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [DATA_W-1:0]       a_in,
  input  logic [DATA_W-1:0]       b_in,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    acc_keep,
  output logic [1:0]              state,
  output logic                    done,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic                    wr_drop,
  output logic [NUM_CH*ACC_W-1:0] acc_out
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem_a [NUM_CH][DEPTH];
  logic [DATA_W-1:0] r_mem_b [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  r_wptr [NUM_CH];
  logic [PTR_W-1:0]  r_rptr [NUM_CH];
  logic [PTR_W:0]    r_cnt [NUM_CH];
  logic [PTR_W:0]    w_cnt_nxt [NUM_CH];
  logic [PROD_W-1:0] r_prod [NUM_CH];
  logic [ACC_W-1:0]  r_acc [NUM_CH];
  logic [ACC_W:0]    w_sum [NUM_CH];
  logic [NUM_CH-1:0] r_full, r_empty, w_push;
  logic              r_v1, r_done, r_wr_drop;
  logic              w_fill_ok, w_pop, w_wr_acc, w_flush, w_acc_clr;

  // Write/pop decode depends only on registered state, so the FSM can consume it.
  always_comb begin
    w_fill_ok = (r_state == S_IDLE) || (r_state == S_FILL);
    w_pop     = (r_state == S_EXEC) && !(|r_empty);
    w_push    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_push[c]    = wr_en && w_fill_ok && (int'(wr_ch) == c) && !r_full[c];
      w_cnt_nxt[c] = r_cnt[c] + (PTR_W+1)'(w_push[c]) - (PTR_W+1)'(w_pop);
      w_sum[c]     = {1'b0, r_acc[c]} + (ACC_W+1)'(r_prod[c]);
    end
    w_wr_acc = |w_push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_wr_acc) w_state_nxt = S_FILL;
      S_FILL: if (((AUTO_START != 0) && (&r_full)) || (start && !(|r_empty)))
                w_state_nxt = S_EXEC;
      S_EXEC: if (!w_pop && !r_v1) w_state_nxt = S_DONE;
      S_DONE: if (clear) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_flush   = (r_state == S_EXEC) && (w_state_nxt == S_DONE);
    w_acc_clr = (r_state == S_DONE) && clear && !acc_keep;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) begin
        r_mem_a[c][r_wptr[c]] <= a_in;
        r_mem_b[c][r_wptr[c]] <= b_in;
      end
    end
  end

  // Leftover entries from unequal fills are discarded when EXEC finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_full  <= '0;
      r_empty <= '1;
    end else if (w_flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_full  <= '0;
      r_empty <= '1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + PTR_W'(1);
        if (w_pop)     r_rptr[c] <= r_rptr[c] + PTR_W'(1);
        r_cnt[c]   <= w_cnt_nxt[c];
        r_full[c]  <= (w_cnt_nxt[c] == (PTR_W+1)'(DEPTH));
        r_empty[c] <= (w_cnt_nxt[c] == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_prod[c] <= '0;
        r_acc[c]  <= '0;
      end
    end else begin
      r_v1 <= w_pop;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_pop)
          r_prod[c] <= PROD_W'(r_mem_a[c][r_rptr[c]]) * PROD_W'(r_mem_b[c][r_rptr[c]]);
        if (w_acc_clr)
          r_acc[c] <= '0;
        else if (r_v1) begin
          if ((SATURATE != 0) && w_sum[c][ACC_W]) r_acc[c] <= '1;
          else                                    r_acc[c] <= w_sum[c][ACC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_done <= w_flush;
      if (wr_en && !w_wr_acc) r_wr_drop <= 1'b1;
    end
  end

  always_comb begin
    acc_out = '0;
    for (int c = 0; c < NUM_CH; c++) acc_out[c*ACC_W +: ACC_W] = r_acc[c];
  end

  assign state   = r_state;
  assign done    = r_done;
  assign full    = r_full;
  assign empty   = r_empty;
  assign wr_drop = r_wr_drop;
endmodule

// File: tb/tb_mac_array_engine.sv
// Bench for mac_array_engine: four parameter variants, one active at a time,
// shared stimulus, reference model and result scoreboard.
module tb_mac_array_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_n_v;
  logic        wr_en, wr_ch, start, clear, acc_keep;
  logic [7:0]  a_in, b_in;
  logic [1:0]  st_a, st_m, st_s, st_w, fu_a, fu_m, fu_s, fu_w, em_a, em_m, em_s, em_w;
  logic        dn_a, dn_m, dn_s, dn_w, dr_a, dr_m, dr_s, dr_w;
  logic [47:0] acc_a, acc_m;
  logic [31:0] acc_s, acc_w;

  mac_array_engine u_a (.clk(clk), .rst_n(rst_n_v[0]), .wr_en(wr_en), .wr_ch(wr_ch),
    .a_in(a_in), .b_in(b_in), .start(start), .clear(clear), .acc_keep(acc_keep),
    .state(st_a), .done(dn_a), .full(fu_a), .empty(em_a), .wr_drop(dr_a), .acc_out(acc_a));
  mac_array_engine #(.AUTO_START(0)) u_m (.clk(clk), .rst_n(rst_n_v[1]), .wr_en(wr_en),
    .wr_ch(wr_ch), .a_in(a_in), .b_in(b_in), .start(start), .clear(clear), .acc_keep(acc_keep),
    .state(st_m), .done(dn_m), .full(fu_m), .empty(em_m), .wr_drop(dr_m), .acc_out(acc_m));
  mac_array_engine #(.ACC_W(16), .SATURATE(1)) u_s (.clk(clk), .rst_n(rst_n_v[2]),
    .wr_en(wr_en), .wr_ch(wr_ch), .a_in(a_in), .b_in(b_in), .start(start), .clear(clear),
    .acc_keep(acc_keep), .state(st_s), .done(dn_s), .full(fu_s), .empty(em_s),
    .wr_drop(dr_s), .acc_out(acc_s));
  mac_array_engine #(.ACC_W(16), .SATURATE(0)) u_w (.clk(clk), .rst_n(rst_n_v[3]),
    .wr_en(wr_en), .wr_ch(wr_ch), .a_in(a_in), .b_in(b_in), .start(start), .clear(clear),
    .acc_keep(acc_keep), .state(st_w), .done(dn_w), .full(fu_w), .empty(em_w),
    .wr_drop(dr_w), .acc_out(acc_w));

  int          sel = 0;
  logic [1:0]  cur_state, cur_full, cur_empty;
  logic        cur_done, cur_drop;
  logic [31:0] cur_acc0, cur_acc1;

  always_comb begin
    cur_state = st_a; cur_done = dn_a; cur_full = fu_a; cur_empty = em_a; cur_drop = dr_a;
    cur_acc0 = {8'd0, acc_a[23:0]}; cur_acc1 = {8'd0, acc_a[47:24]};
    case (sel)
      1: begin
        cur_state = st_m; cur_done = dn_m; cur_full = fu_m; cur_empty = em_m; cur_drop = dr_m;
        cur_acc0 = {8'd0, acc_m[23:0]}; cur_acc1 = {8'd0, acc_m[47:24]};
      end
      2: begin
        cur_state = st_s; cur_done = dn_s; cur_full = fu_s; cur_empty = em_s; cur_drop = dr_s;
        cur_acc0 = {16'd0, acc_s[15:0]}; cur_acc1 = {16'd0, acc_s[31:16]};
      end
      3: begin
        cur_state = st_w; cur_done = dn_w; cur_full = fu_w; cur_empty = em_w; cur_drop = dr_w;
        cur_acc0 = {16'd0, acc_w[15:0]}; cur_acc1 = {16'd0, acc_w[31:16]};
      end
      default: ;
    endcase
  end

  typedef struct { int ch; int a; int b; logic [1:0] exp_full; logic [1:0] exp_empty; } wvec_t;
  typedef struct { longint acc0; longint acc1; } exp_t;

  wvec_t  tv[16];
  exp_t   sb[$];
  int     mq_a[2][$];
  int     mq_b[2][$];
  longint m_acc[2];
  longint m_mask;
  bit     m_sat;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_sel(input int s, input longint mask, input bit sat);
    sel = s; rst_n_v = 4'b0000;
    wr_en = 0; wr_ch = 0; a_in = 0; b_in = 0; start = 0; clear = 0; acc_keep = 0;
    step(2);
    rst_n_v = 4'(1 << s);
    step(1);
    m_acc = '{0, 0}; mq_a[0].delete(); mq_a[1].delete(); mq_b[0].delete(); mq_b[1].delete();
    sb.delete(); m_mask = mask; m_sat = sat;
  endtask

  task automatic do_write(input int ch, input int a, input int b, input bit ok);
    wr_en = 1; wr_ch = ch[0]; a_in = a[7:0]; b_in = b[7:0];
    step();
    wr_en = 0;
    if (ok) begin mq_a[ch].push_back(a); mq_b[ch].push_back(b); end
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
  endtask

  // Model of one run: lockstep pops up to the shortest queue, then flush.
  task automatic begin_run();
    exp_t   e;
    longint s;
    int     n;
    n = (mq_a[0].size() < mq_a[1].size()) ? mq_a[0].size() : mq_a[1].size();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < n; i++) begin
        s = m_acc[c] + longint'(mq_a[c][i]) * longint'(mq_b[c][i]);
        if (m_sat && s > m_mask) s = m_mask;
        else                     s = s & m_mask;
        m_acc[c] = s;
      end
      mq_a[c].delete(); mq_b[c].delete();
    end
    e.acc0 = m_acc[0]; e.acc1 = m_acc[1];
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int k0, output int k);
    exp_t e;
    k = k0;
    while (cur_done !== 1'b1 && k < 60) begin step(); k++; end
    check({tag, "_done_seen"}, cur_done, 1);
    check({tag, "_sb_pending"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_acc0"}, cur_acc0, e.acc0);
      check({tag, "_acc1"}, cur_acc1, e.acc1);
      check({tag, "_state"}, cur_state, 3);
      check({tag, "_empty"}, cur_empty, 2'b11);
      check({tag, "_full"}, cur_full, 2'b00);
    end
    step();
    check({tag, "_done_single"}, cur_done, 0);
  endtask

  task automatic do_clear(input string tag, input bit keep);
    clear = 1; acc_keep = keep; step(); clear = 0; acc_keep = 0;
    if (!keep) m_acc = '{0, 0};
    check({tag, "_clr_state"}, cur_state, 0);
    check({tag, "_clr_acc0"}, cur_acc0, m_acc[0]);
    check({tag, "_clr_acc1"}, cur_acc1, m_acc[1]);
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      do_write(tv[i].ch, tv[i].a, tv[i].b, 1'b1);
      check($sformatf("%s_full%0d", tag, i), cur_full, tv[i].exp_full);
      check($sformatf("%s_empty%0d", tag, i), cur_empty, tv[i].exp_empty);
      if (i == 0) check({tag, "_fill_state"}, cur_state, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  seen;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) tv[i] = '{0, i + 1, 1, (i == 7) ? 2'b01 : 2'b00, 2'b10};
      else       tv[i] = '{1, 255, 255, (i == 15) ? 2'b11 : 2'b01, 2'b00};
    end

    // Defaults: reset state, auto start after the 16th write.
    reset_sel(0, 64'hFF_FFFF, 0);
    check("rst_state", cur_state, 0);
    check("rst_empty", cur_empty, 2'b11);
    check("rst_full", cur_full, 2'b00);
    check("rst_drop", cur_drop, 0);
    check("rst_done", cur_done, 0);
    check("rst_acc", {cur_acc1, cur_acc0}, 0);
    apply_table("t1");
    check("t1_pre_exec_state", cur_state, 1);
    begin_run();
    wait_done("t1", 0, k);
    check("t1_acc0_const", cur_acc0, 36);
    check("t1_acc1_const", cur_acc1, 520200);

    // Overfill of ch0 dropped; results exclude it.
    do_clear("t3", 0);
    check("t3_drop0", cur_drop, 0);
    for (int i = 0; i < 8; i++) do_write(0, i + 1, 2, 1'b1);
    check("t3_full_ch0", cur_full, 2'b01);
    do_write(0, 200, 200, 1'b0);
    check("t3_drop1", cur_drop, 1);
    check("t3_full_after_drop", cur_full, 2'b01);
    check("t3_state_fill", cur_state, 1);
    for (int i = 0; i < 8; i++) do_write(1, i + 1, i + 1, 1'b1);
    begin_run();
    wait_done("t3", 0, k);

    // Unequal fills with start: two lockstep pops, residue flushed.
    do_clear("t4", 0);
    for (int i = 0; i < 4; i++) do_write(0, 10 + i, 1, 1'b1);
    for (int i = 0; i < 2; i++) do_write(1, 3, 4, 1'b1);
    check("t4_fill_state", cur_state, 1);
    do_start();
    check("t4_exec_state", cur_state, 2);
    begin_run();
    wait_done("t4", 0, k);

    // Manual start: ignored while not allowed; start with write; DONE timing.
    reset_sel(1, 64'hFF_FFFF, 0);
    do_start();
    check("t2_start_idle", cur_state, 0);
    for (int i = 0; i < 3; i++) do_write(0, 2 + i, 5, 1'b1);
    do_start();
    check("t2_start_ch1_empty", cur_state, 1);
    for (int i = 0; i < 2; i++) do_write(1, 10, 10, 1'b1);
    wr_en = 1; wr_ch = 1; a_in = 10; b_in = 10; start = 1;
    step();
    wr_en = 0; start = 0;
    mq_a[1].push_back(10); mq_b[1].push_back(10);
    check("t2_exec_entry", cur_state, 2);
    check("t2_drop_before", cur_drop, 0);
    begin_run();
    wr_en = 1; wr_ch = 0; a_in = 99; b_in = 99;
    step();
    wr_en = 0;
    wait_done("t2", 1, k);
    check("t2_done_cycle", k, 5);
    check("t2_exec_write_drop", cur_drop, 1);
    do_clear("t2", 0);

    // 16-bit accumulators: saturate vs wrap.
    reset_sel(2, 64'hFFFF, 1);
    for (int i = 0; i < 16; i++) do_write(i / 8, 255, 255, 1'b1);
    begin_run();
    wait_done("t5s", 0, k);
    check("t5s_const", cur_acc0, 16'hFFFF);
    reset_sel(3, 64'hFFFF, 0);
    for (int i = 0; i < 16; i++) do_write(i / 8, 255, 255, 1'b1);
    begin_run();
    wait_done("t5w", 0, k);
    check("t5w_const", cur_acc1, 61448);

    // Reset mid-EXEC aborts; then accumulate two runs with acc_keep.
    reset_sel(0, 64'hFF_FFFF, 0);
    apply_table("t6a");
    step(3);
    check("t6_in_exec", cur_state, 2);
    rst_n_v = 4'b0000;
    step(2);
    check("t6_rst_state", cur_state, 0);
    check("t6_rst_acc", {cur_acc1, cur_acc0}, 0);
    check("t6_rst_empty", cur_empty, 2'b11);
    rst_n_v = 4'b0001;
    m_acc = '{0, 0}; mq_a[0].delete(); mq_a[1].delete(); mq_b[0].delete(); mq_b[1].delete();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cur_done === 1'b1) seen = 1;
    end
    check("t6_no_done", seen, 0);
    check("t6_idle_after", cur_state, 0);
    apply_table("t6b");
    begin_run();
    wait_done("t6b", 0, k);
    do_clear("t6k", 1);
    apply_table("t6c");
    begin_run();
    wait_done("t6c", 0, k);
    check("t6_keep_const", cur_acc0, 72);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
